sad_trigger_sequencer: RTL and testbench
========================================

Name: sad_trigger_sequencer

Overview:
- Sequences the SAD pattern-match trigger on the ADC sample clock, between the SAD comparator's raw per-sample match and the capture trigger input.
- Gates the SAD engine with sad_active.
- Skips the first N matches, emits up to M stretched trigger pulses per arm, and enforces a hold-off window after each pulse.
- Configuration is latched at arm time, so USB-domain register writes never disturb a run in progress.

Parameters:
- pHOLDOFF_WIDTH, 16: width of the hold-off counter and cfg_holdoff.
- pCNT_WIDTH, 8: width of the skip, trigger-count and match-count fields.
- pTIMEOUT_WIDTH, 32: width of cfg_timeout and the timeout counter (used only with the optional feature).

Ports:
- clk_adc  in  1  ADC sample clock; the only clock.
- reset_n  in  1  asynchronous reset, active-low.
- armed_and_ready  in  1  capture armed (level); a rising edge starts a run, a low level aborts it.
- sad_match  in  1  raw SAD match, one-cycle pulse per matching sample.
- cfg_skip  in  pCNT_WIDTH  number of matches to discard before the first trigger.
- cfg_num_triggers  in  pCNT_WIDTH  triggers per arm; 0 means unlimited.
- cfg_trig_len  in  8  trigger pulse length in cycles; 0 is treated as 1.
- cfg_holdoff  in  pHOLDOFF_WIDTH  cycles after each pulse during which matches are ignored.
- cfg_timeout  in  pTIMEOUT_WIDTH  cycles with no match before the run stops (optional feature only).
- sad_active  out  1  enables the SAD engine.
- trigger  out  1  registered trigger pulse.
- busy  out  1  high while not in IDLE or DONE.
- done  out  1  high in DONE.
- trig_count  out  pCNT_WIDTH  triggers emitted in this arm.
- match_count  out  pCNT_WIDTH  total sad_match pulses seen while sad_active, saturating.
- timed_out  out  1  sticky timeout flag (optional feature only).

Behaviour:
- Reset (reset_n low, async): state=IDLE; all outputs 0; all counters 0; latched configuration 0.
- Arm edge detect: arm_q is armed_and_ready registered once. A start is `armed_and_ready & ~arm_q`.
- IDLE:
  - sad_active=0.
  - On start: latch all cfg_* inputs, clear trig_count, match_count and the skip counter, then go to ARMED.
  - sad_active rises the cycle after the start edge.
- ARMED:
  - sad_active=1.
  - On sad_match with skip_cnt < skip: skip_cnt++, no trigger.
  - On sad_match otherwise: go to PULSE and set trigger=1 at the same edge, so trigger is visible 1 cycle after sad_match; trig_count++.
- PULSE:
  - trigger=1 for exactly max(trig_len,1) cycles; sad_match is counted in match_count but otherwise ignored.
  - At the end of the pulse: if num_triggers≠0 and trig_count==num_triggers, go to DONE.
  - Otherwise, if holdoff==0, go to ARMED.
  - Otherwise go to HOLDOFF.
- HOLDOFF:
  - trigger=0; sad_active stays 1; matches are ignored but counted.
  - Stays exactly holdoff cycles, then goes to ARMED.
- DONE:
  - sad_active=0, trigger=0, done=1.
  - Holds until armed_and_ready is low, then goes to IDLE.
  - A re-arm requires a fresh rising edge.
- Abort: armed_and_ready low in ARMED, PULSE or HOLDOFF → IDLE at the next edge.
  - trigger and sad_active drop the same edge, so a pulse may be truncated.
  - Counters keep their values for readback until the next start.
- Simultaneous events:
  - A match on the start cycle is ignored, because sad_active is still 0.
  - A match in the last HOLDOFF cycle is ignored.
  - A match on the first ARMED cycle is accepted.
- Widths:
  - match_count saturates at all-ones.
  - trig_count cannot exceed num_triggers when it is nonzero.
  - In unlimited mode trig_count wraps modulo 2^pCNT_WIDTH.
- All outputs are registered; there is no combinational path from any input to any output.

Optional Feature:
SAD_SEQ_TIMEOUT_EN
- Defined:
  - A timeout counter runs in ARMED and is cleared on each accepted or skipped match and on entry to ARMED.
  - When it reaches timeout (with timeout≠0): go to DONE and set timed_out=1.
  - timed_out clears on the next start.
- Undefined:
  - cfg_timeout is ignored and no timeout logic is synthesized.
  - timed_out is tied to 0.
  - ARMED waits indefinitely.

Test Plan:
- Reset mid-PULSE (reset_n low for 1 cycle) → all outputs 0 immediately (async), state IDLE, no trigger after release until a new arm edge.
- skip=2, num=1, len=4: arm, matches at t=10, 20, 30 → single trigger high for cycles 31–34; trig_count=1; match_count=3; done=1; sad_active=0 from cycle 35.
- num=3, len=1, holdoff=5: continuous sad_match every cycle → triggers exactly 7 cycles apart (1 pulse + 5 holdoff + 1 ARMED accept); trig_count=3; then DONE.
- num=0 (unlimited), holdoff=0, len=2: matches every 10 cycles for 300 cycles → 30 pulses of 2 cycles; busy stays 1; done stays 0.
- Abort: len=100, drop armed_and_ready 5 cycles into the pulse → trigger low the next cycle; IDLE; counters held; re-raising arm restarts with counters cleared.
- SAD_SEQ_TIMEOUT_EN, timeout=50, no matches → timed_out=1 and done=1 at cycle 51 after ARMED entry.
- SAD_SEQ_TIMEOUT_EN, timeout=50, match every 40 cycles → never times out.

Source files
------------

// File: rtl/sad_trigger_sequencer.sv
// sad_trigger_sequencer: gates the SAD engine and turns raw matches into stretched, counted, held-off capture triggers
// Ports: clk_adc/reset_n (async, active-low); armed_and_ready starts a run on its rising edge and aborts it when low;
//   sad_match is the raw per-sample match; cfg_* are latched at arm time; sad_active enables the SAD engine;
//   trigger is the capture pulse; busy/done report progress; trig_count/match_count are readback counters;
//   timed_out is the sticky no-match timeout flag.
// Optional: define SAD_SEQ_TIMEOUT_EN to stop a run after cfg_timeout match-free cycles in ARMED.
module sad_trigger_sequencer #(
   parameter int pHOLDOFF_WIDTH = 16,
   parameter int pCNT_WIDTH = 8,
   parameter int pTIMEOUT_WIDTH = 32
) (
   input  logic                      clk_adc,
   input  logic                      reset_n,
   input  logic                      armed_and_ready,
   input  logic                      sad_match,
   input  logic [pCNT_WIDTH-1:0]     cfg_skip,
   input  logic [pCNT_WIDTH-1:0]     cfg_num_triggers,
   input  logic [7:0]                cfg_trig_len,
   input  logic [pHOLDOFF_WIDTH-1:0] cfg_holdoff,
   input  logic [pTIMEOUT_WIDTH-1:0] cfg_timeout,
   output logic                      sad_active,
   output logic                      trigger,
   output logic                      busy,
   output logic                      done,
   output logic [pCNT_WIDTH-1:0]     trig_count,
   output logic [pCNT_WIDTH-1:0]     match_count,
   output logic                      timed_out
);
   typedef enum logic [2:0] {IDLE, ARMED, PULSE, HOLDOFF, DONE} state_e;
   state_e state_q, state_d;
   logic arm_q;
   logic [pCNT_WIDTH-1:0] skip_q, skip_d, num_q, num_d, skip_cnt_q, skip_cnt_d;
   logic [pCNT_WIDTH-1:0] trig_count_q, trig_count_d, match_count_q, match_count_d;
   logic [7:0] len_q, len_d, pulse_cnt_q, pulse_cnt_d, len_eff;
   logic [pHOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d, hold_cnt_q, hold_cnt_d;
   logic start;
   assign start = armed_and_ready & ~arm_q;
   assign len_eff = (len_q == 8'd0) ? 8'd1 : len_q;
   // Outputs decode the state register only, so no input reaches an output combinationally.
   assign sad_active = (state_q == ARMED) | (state_q == PULSE) | (state_q == HOLDOFF);
   assign trigger = state_q == PULSE;
   assign busy = (state_q != IDLE) & (state_q != DONE);
   assign done = state_q == DONE;
   assign trig_count = trig_count_q;
   assign match_count = match_count_q;
`ifdef SAD_SEQ_TIMEOUT_EN
   logic [pTIMEOUT_WIDTH-1:0] timeout_q, timeout_d, tmo_cnt_q, tmo_cnt_d;
   logic timed_out_q, timed_out_d;
   assign timed_out = timed_out_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^cfg_timeout;
   assign timed_out = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      skip_d = skip_q;
      num_d = num_q;
      len_d = len_q;
      holdoff_d = holdoff_q;
      skip_cnt_d = skip_cnt_q;
      pulse_cnt_d = pulse_cnt_q;
      hold_cnt_d = hold_cnt_q;
      trig_count_d = trig_count_q;
      match_count_d = (sad_active && sad_match && match_count_q != '1) ? match_count_q + 1'b1 : match_count_q;
`ifdef SAD_SEQ_TIMEOUT_EN
      timeout_d = timeout_q;
      timed_out_d = timed_out_q;
      // Entry to ARMED and every match (skipped or accepted) restart the match-free count.
      tmo_cnt_d = (state_q == ARMED && !sad_match) ? tmo_cnt_q + 1'b1 : '0;
`endif
      case (state_q)
         IDLE: if (start) begin
            skip_d = cfg_skip;
            num_d = cfg_num_triggers;
            len_d = cfg_trig_len;
            holdoff_d = cfg_holdoff;
            skip_cnt_d = '0;
            trig_count_d = '0;
            match_count_d = '0;
`ifdef SAD_SEQ_TIMEOUT_EN
            timeout_d = cfg_timeout;
            timed_out_d = 1'b0;
`endif
            state_d = ARMED;
         end
         ARMED: if (!armed_and_ready) state_d = IDLE;
         else if (sad_match) begin
            if (skip_cnt_q < skip_q) skip_cnt_d = skip_cnt_q + 1'b1;
            else begin
               state_d = PULSE;
               pulse_cnt_d = 8'd1;
               trig_count_d = trig_count_q + 1'b1;
            end
         end
`ifdef SAD_SEQ_TIMEOUT_EN
         else if (timeout_q != '0 && tmo_cnt_q == timeout_q) begin
            state_d = DONE;
            timed_out_d = 1'b1;
         end
`endif
         PULSE: if (!armed_and_ready) state_d = IDLE;
         else if (pulse_cnt_q >= len_eff) begin
            if (num_q != '0 && trig_count_q == num_q) state_d = DONE;
            else if (holdoff_q == '0) state_d = ARMED;
            else begin
               state_d = HOLDOFF;
               hold_cnt_d = {{(pHOLDOFF_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         else pulse_cnt_d = pulse_cnt_q + 1'b1;
         HOLDOFF: if (!armed_and_ready) state_d = IDLE;
         else if (hold_cnt_q >= holdoff_q) state_d = ARMED;
         else hold_cnt_d = hold_cnt_q + 1'b1;
         DONE: if (!armed_and_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_adc or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         arm_q <= 1'b0;
         skip_q <= '0;
         num_q <= '0;
         len_q <= '0;
         holdoff_q <= '0;
         skip_cnt_q <= '0;
         pulse_cnt_q <= '0;
         hold_cnt_q <= '0;
         trig_count_q <= '0;
         match_count_q <= '0;
      end else begin
         state_q <= state_d;
         arm_q <= armed_and_ready;
         skip_q <= skip_d;
         num_q <= num_d;
         len_q <= len_d;
         holdoff_q <= holdoff_d;
         skip_cnt_q <= skip_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         trig_count_q <= trig_count_d;
         match_count_q <= match_count_d;
      end
   end
`ifdef SAD_SEQ_TIMEOUT_EN
   always_ff @(posedge clk_adc or negedge reset_n) begin
      if (!reset_n) begin
         timeout_q <= '0;
         tmo_cnt_q <= '0;
         timed_out_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
         tmo_cnt_q <= tmo_cnt_d;
         timed_out_q <= timed_out_d;
      end
   end
`endif
endmodule

// File: tb/tb_sad_trigger_sequencer.sv
// tb_sad_trigger_sequencer: directed self-checking bench for sad_trigger_sequencer
module tb_sad_trigger_sequencer;
   logic clk_adc = 1'b0;
   logic reset_n, armed_and_ready, sad_match;
   logic [7:0] cfg_skip, cfg_num_triggers, cfg_trig_len;
   logic [15:0] cfg_holdoff;
   logic [31:0] cfg_timeout;
   logic sad_active, trigger, busy, done, timed_out;
   logic [7:0] trig_count, match_count;
   int checks = 0;
   int errors = 0;
   always #5 clk_adc = ~clk_adc;
   sad_trigger_sequencer dut (
      .clk_adc(clk_adc), .reset_n(reset_n), .armed_and_ready(armed_and_ready), .sad_match(sad_match),
      .cfg_skip(cfg_skip), .cfg_num_triggers(cfg_num_triggers), .cfg_trig_len(cfg_trig_len),
      .cfg_holdoff(cfg_holdoff), .cfg_timeout(cfg_timeout), .sad_active(sad_active), .trigger(trigger),
      .busy(busy), .done(done), .trig_count(trig_count), .match_count(match_count), .timed_out(timed_out)
   );
   task automatic step;
      @(posedge clk_adc);
      #1;
   endtask
   task automatic setup(input logic [7:0] sk, input logic [7:0] nm, input logic [7:0] ln,
                        input logic [15:0] ho, input logic [31:0] to);
      cfg_skip = sk;
      cfg_num_triggers = nm;
      cfg_trig_len = ln;
      cfg_holdoff = ho;
      cfg_timeout = to;
      armed_and_ready = 1'b0;
      sad_match = 1'b0;
      step;
      step;
   endtask
   task automatic test_reset;
      reset_n = 1'b1;
      armed_and_ready = 1'b0;
      sad_match = 1'b0;
      cfg_skip = '0;
      cfg_num_triggers = '0;
      cfg_trig_len = '0;
      cfg_holdoff = '0;
      cfg_timeout = '0;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({sad_active, trigger, busy, done, timed_out, trig_count, match_count} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b expected 0", {sad_active, trigger, busy, done, timed_out, trig_count, match_count});
      end
      step;
      step;
      reset_n = 1'b1;
      step;
   endtask
   task automatic test_reset_mid_pulse;
      setup(8'd0, 8'd0, 8'd100, 16'd0, 32'd0);
      armed_and_ready = 1'b1;
      step;
      sad_match = 1'b1;
      step;
      sad_match = 1'b0;
      step;
      step;
      step;
      checks++;
      if (trigger !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_trigger got %b expected 1", trigger);
      end
      #2 reset_n = 1'b0;
      armed_and_ready = 1'b0;
      #1;
      checks++;
      if ({sad_active, trigger, busy, done, trig_count, match_count} !== 20'd0) begin
         errors++;
         $display("FAIL reset_mid_pulse got %b expected 0", {sad_active, trigger, busy, done, trig_count, match_count});
      end
      step;
      reset_n = 1'b1;
      sad_match = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step;
         checks++;
         if (trigger !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle cycle %0d trigger %b busy %b expected 0 0", i, trigger, busy);
         end
      end
      sad_match = 1'b0;
   endtask
   task automatic test_skip;
      setup(8'd2, 8'd1, 8'd4, 16'd0, 32'd0);
      armed_and_ready = 1'b1;
      for (int t = 0; t <= 40; t++) begin
         sad_match = (t == 10 || t == 20 || t == 30);
         checks++;
         if (trigger !== (t >= 31 && t <= 34) || sad_active !== (t >= 1 && t <= 34) || done !== (t >= 35)) begin
            errors++;
            $display("FAIL skip cycle %0d trig/active/done %b%b%b expected %b%b%b", t, trigger, sad_active, done,
                     t >= 31 && t <= 34, t >= 1 && t <= 34, t >= 35);
         end
         step;
      end
      checks++;
      if (trig_count !== 8'd1 || match_count !== 8'd3) begin
         errors++;
         $display("FAIL skip_counts trig %0d match %0d expected 1 3", trig_count, match_count);
      end
      armed_and_ready = 1'b0;
      step;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_release done %b busy %b expected 0 0", done, busy);
      end
   endtask
   task automatic test_holdoff;
      setup(8'd0, 8'd3, 8'd1, 16'd5, 32'd0);
      armed_and_ready = 1'b1;
      sad_match = 1'b1;
      for (int t = 0; t <= 25; t++) begin
         checks++;
         if (trigger !== (t == 2 || t == 9 || t == 16) || done !== (t >= 17)) begin
            errors++;
            $display("FAIL holdoff cycle %0d trig %b done %b expected %b %b", t, trigger, done,
                     t == 2 || t == 9 || t == 16, t >= 17);
         end
         step;
      end
      checks++;
      if (trig_count !== 8'd3 || match_count !== 8'd16) begin
         errors++;
         $display("FAIL holdoff_counts trig %0d match %0d expected 3 16", trig_count, match_count);
      end
      sad_match = 1'b0;
      armed_and_ready = 1'b0;
      step;
   endtask
   task automatic test_unlimited;
      int rises;
      logic prev;
      rises = 0;
      prev = 1'b0;
      setup(8'd0, 8'd0, 8'd2, 16'd0, 32'd0);
      armed_and_ready = 1'b1;
      for (int t = 0; t <= 305; t++) begin
         sad_match = (t > 0 && t <= 300 && t % 10 == 0);
         checks++;
         if (trigger !== (t >= 11 && t <= 302 && (t % 10 == 1 || t % 10 == 2)) || busy !== (t >= 1) || done !== 1'b0) begin
            errors++;
            $display("FAIL unlimited cycle %0d trig %b busy %b done %b", t, trigger, busy, done);
         end
         if (trigger && !prev) rises++;
         prev = trigger;
         step;
      end
      checks++;
      if (rises != 30 || trig_count !== 8'd30 || match_count !== 8'd30) begin
         errors++;
         $display("FAIL unlimited_counts pulses %0d trig %0d match %0d expected 30 30 30", rises, trig_count, match_count);
      end
      armed_and_ready = 1'b0;
      step;
   endtask
   task automatic test_len_zero;
      setup(8'd0, 8'd1, 8'd0, 16'd0, 32'd0);
      armed_and_ready = 1'b1;
      for (int t = 0; t <= 6; t++) begin
         sad_match = (t == 2);
         checks++;
         if (trigger !== (t == 3) || done !== (t >= 4)) begin
            errors++;
            $display("FAIL len_zero cycle %0d trig %b done %b expected %b %b", t, trigger, done, t == 3, t >= 4);
         end
         step;
      end
      armed_and_ready = 1'b0;
      step;
   endtask
   task automatic test_abort;
      logic [7:0] exp_cnt;
      setup(8'd0, 8'd0, 8'd100, 16'd0, 32'd0);
      for (int t = 0; t <= 14; t++) begin
         armed_and_ready = (t < 6) || (t >= 10);
         sad_match = (t == 1);
         exp_cnt = (t >= 2 && t <= 10) ? 8'd1 : 8'd0;
         checks++;
         if (trigger !== (t >= 2 && t <= 6) || busy !== ((t >= 1 && t <= 6) || t >= 11) || sad_active !== busy) begin
            errors++;
            $display("FAIL abort cycle %0d trig %b busy %b active %b", t, trigger, busy, sad_active);
         end
         if (t >= 2) begin
            checks++;
            if (trig_count !== exp_cnt || match_count !== exp_cnt) begin
               errors++;
               $display("FAIL abort_counts cycle %0d trig %0d match %0d expected %0d", t, trig_count, match_count, exp_cnt);
            end
         end
         step;
      end
      armed_and_ready = 1'b0;
      step;
      step;
   endtask
`ifdef SAD_SEQ_TIMEOUT_EN
   task automatic test_timeout;
      setup(8'd0, 8'd0, 8'd1, 16'd0, 32'd50);
      armed_and_ready = 1'b1;
      for (int t = 0; t <= 55; t++) begin
         checks++;
         if (done !== (t >= 52) || timed_out !== (t >= 52) || busy !== (t >= 1 && t < 52)) begin
            errors++;
            $display("FAIL timeout cycle %0d done %b timed_out %b busy %b", t, done, timed_out, busy);
         end
         step;
      end
      armed_and_ready = 1'b0;
      step;
      armed_and_ready = 1'b1;
      step;
      checks++;
      if (timed_out !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_clear timed_out %b busy %b expected 0 1", timed_out, busy);
      end
      armed_and_ready = 1'b0;
      step;
      setup(8'd0, 8'd0, 8'd1, 16'd0, 32'd50);
      armed_and_ready = 1'b1;
      for (int t = 0; t <= 200; t++) begin
         sad_match = (t > 0 && t % 40 == 0);
         checks++;
         if (timed_out !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fed cycle %0d timed_out %b done %b expected 0 0", t, timed_out, done);
         end
         step;
      end
      sad_match = 1'b0;
      armed_and_ready = 1'b0;
      step;
   endtask
`else
   task automatic test_timeout;
      setup(8'd0, 8'd0, 8'd1, 16'd0, 32'd5);
      armed_and_ready = 1'b1;
      for (int t = 0; t <= 30; t++) begin
         checks++;
         if (timed_out !== 1'b0 || busy !== (t >= 1) || done !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout cycle %0d timed_out %b busy %b done %b", t, timed_out, busy, done);
         end
         step;
      end
      armed_and_ready = 1'b0;
      step;
   endtask
`endif
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      test_reset;
      test_reset_mid_pulse;
      test_skip;
      test_holdoff;
      test_unlimited;
      test_len_zero;
      test_abort;
      test_timeout;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
